// File: rtl/alu_arbiter_if.sv
// Bus bundle for the shared ALU arbiter.
// Two request channels, the ALU drive/return pair, and the response channel.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CW-1:0]    req0_ctrl;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CW-1:0]    req1_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [CW-1:0]    alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req1_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req1_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports: clk, reset (async active-low), bus (slave side of alu_arbiter_if).
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CW     = 5,
  parameter int MAX_OP = 9
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_OP);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    ctrl_q;
  logic             id_q;
  logic             last_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             err_q;

  logic             r0;
  logic             r1;
  logic             acc;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [CW-1:0]    sel_c;
  logic             ill;

  // last_q==1 means requester 1 was granted last, so 0 has priority
  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    if (state == IDLE) begin
      r0 = bus.req0_valid & (~bus.req1_valid | last_q);
      r1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    end
  end

  assign acc   = r0 | r1;
  assign sel_a = r1 ? bus.req1_a : bus.req0_a;
  assign sel_b = r1 ? bus.req1_b : bus.req0_b;
  assign sel_c = r1 ? bus.req1_ctrl : bus.req0_ctrl;
  assign ill   = sel_c > MAXC;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = ill ? RESP : EXEC;
      EXEC: nxt = RESP;
      RESP: if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        ctrl_q <= sel_c;
        id_q   <= r1;
        last_q <= r1;
        // illegal op: response is built here, EXEC is skipped
        if (ill) begin
          res_q  <= '0;
          zero_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
      if (state == EXEC) begin
        res_q  <= bus.alu_result;
        zero_q <= bus.alu_zero;
        err_q  <= 1'b0;
      end
    end
  end

  assign bus.req0_ready  = r0;
  assign bus.req1_ready  = r1;
  assign bus.alu_a       = (state == EXEC) ? a_q : '0;
  assign bus.alu_b       = (state == EXEC) ? b_q : '0;
  assign bus.alu_control = (state == EXEC) ? ctrl_q : '0;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_err     = err_q;
  assign bus.busy        = (state != IDLE);

endmodule
